// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a two-flop line synchroniser, midpoint bit sampling and
// stop-bit checking, feeding a show-ahead receive FIFO popped by the peripheral bus.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 234,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          raw_clk,
  input  logic                          reset_n,
  input  logic                          rx_pin,
  input  logic                          rx_read,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          rx_overflow,
  output logic                          frame_error,
  input  logic                          clear_errors
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [PW:0]   FULL_CNT = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_t;

  logic          sync1_q;
  logic          rx_s_q;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW:0]   count_q;
  logic          ovf_q;
  logic          ferr_q;

  logic stop_tick;
  logic push;
  logic ferr_set;
  logic full;
  logic pop;
  logic wr_en;
  logic ovf_set;

  always_ff @(posedge raw_clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= rx_pin;
      rx_s_q  <= sync1_q;
    end
  end

  // Receive FSM: counter restarts on entering START and DATA, then wraps bit by bit.
  always_ff @(posedge raw_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            cnt_q   <= '0;
            state_q <= START;
          end
        end
        START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_q <= '0;
            idx_q <= '0;
            state_q <= rx_s_q ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q          <= '0;
            shift_q[idx_q] <= rx_s_q;
            idx_q          <= idx_q + 1'b1;
            if (idx_q == 3'd7) state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= rx_s_q ? IDLE : BRK;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        BRK: begin
          if (rx_s_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stop_tick = (state_q == STOP) && (cnt_q == CNT_LAST);
  assign push      = stop_tick && rx_s_q;
  assign ferr_set  = stop_tick && !rx_s_q;

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign full    = (count_q == FULL_CNT);
  assign pop     = rx_read && (count_q != '0);
  assign wr_en   = push && (!full || pop);
  assign ovf_set = push && full && !pop;

  always_ff @(posedge raw_clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge raw_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (ovf_set)           ovf_q <= 1'b1;
      else if (clear_errors) ovf_q <= 1'b0;
      if (ferr_set)          ferr_q <= 1'b1;
      else if (clear_errors) ferr_q <= 1'b0;
    end
  end

  assign rx_valid    = (count_q != '0);
  assign rx_data     = rx_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign fifo_count  = count_q;
  assign rx_overflow = ovf_q;
  assign frame_error = ferr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 8 clocks per bit and a 4-entry FIFO.
module tb_uart_rx_fifo;

  logic       raw_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_pin = 1'b1;
  logic       rx_read = 1'b0;
  logic       clear_errors = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [2:0] fifo_count;
  logic       rx_overflow;
  logic       frame_error;

  int checks = 0;
  int failures = 0;

  uart_rx_fifo #(.CLKS_PER_BIT(8), .FIFO_DEPTH(4)) dut (
    .raw_clk      (raw_clk),
    .reset_n      (reset_n),
    .rx_pin       (rx_pin),
    .rx_read      (rx_read),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .fifo_count   (fifo_count),
    .rx_overflow  (rx_overflow),
    .frame_error  (frame_error),
    .clear_errors (clear_errors)
  );

  always #5 raw_clk = ~raw_clk;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_valid;
    logic [7:0] exp_rdata;
    logic       exp_ferr;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drives start + 8 data bits + stop level; returns at the negedge after the 78th edge,
  // one edge before the receiver samples the stop bit.
  task automatic frame_to_sample(input logic [7:0] b, input logic stop);
    rx_pin = 1'b0;
    repeat (8) @(negedge raw_clk);
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i];
      repeat (8) @(negedge raw_clk);
    end
    rx_pin = stop;
    repeat (6) @(negedge raw_clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic rd, input logic clr);
    frame_to_sample(b, stop);
    rx_read = rd;
    clear_errors = clr;
    @(negedge raw_clk);
    rx_read = 1'b0;
    clear_errors = 1'b0;
    @(negedge raw_clk);
    rx_pin = 1'b1;
  endtask

  task automatic pop_chk(input string nm, input logic [7:0] exp);
    chk({nm, "_valid"}, rx_valid, 1);
    chk({nm, "_data"}, rx_data, exp);
    rx_read = 1'b1;
    @(negedge raw_clk);
    rx_read = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_errors = 1'b1;
    @(negedge raw_clk);
    clear_errors = 1'b0;
  endtask

  initial begin
    tbl[0] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
    tbl[1] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0};
    tbl[2] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0};
    tbl[3] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b0};
    tbl[4] = '{8'hC3, 1'b0, 1'b0, 8'h00, 1'b1};
    tbl[5] = '{8'h7E, 1'b1, 1'b1, 8'h7E, 1'b0};

    // Reset state
    #1;
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ovf", rx_overflow, 0);
    chk("rst_ferr", frame_error, 0);
    repeat (3) @(negedge raw_clk);
    reset_n = 1'b1;
    repeat (4) @(negedge raw_clk);

    // Reset mid-frame: a stored byte and a partial 0x55 are both discarded
    send_frame(8'h42, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_count", fifo_count, 1);
    repeat (4) @(negedge raw_clk);
    rx_pin = 1'b0;
    repeat (8) @(negedge raw_clk);
    for (int i = 0; i < 3; i++) begin
      rx_pin = i[0] ? 1'b0 : 1'b1;
      repeat (8) @(negedge raw_clk);
    end
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", rx_valid, 0);
    chk("arst_count", fifo_count, 0);
    chk("arst_data", rx_data, 0);
    for (int i = 3; i < 8; i++) begin
      @(negedge raw_clk);
      rx_pin = i[0] ? 1'b0 : 1'b1;
      repeat (7) @(negedge raw_clk);
    end
    rx_pin = 1'b1;
    repeat (8) @(negedge raw_clk);
    reset_n = 1'b1;
    repeat (100) @(negedge raw_clk);
    chk("post_rst_valid", rx_valid, 0);
    chk("post_rst_count", fifo_count, 0);
    chk("post_rst_ferr", frame_error, 0);

    // Single byte: exact push latency
    frame_to_sample(8'hA5, 1'b1);
    chk("single_before", fifo_count, 0);
    @(negedge raw_clk);
    chk("single_valid", rx_valid, 1);
    chk("single_data", rx_data, 8'hA5);
    chk("single_count", fifo_count, 1);
    @(negedge raw_clk);
    rx_read = 1'b1;
    @(negedge raw_clk);
    rx_read = 1'b0;
    chk("single_popped", rx_valid, 0);

    // Read of an empty FIFO is ignored
    rx_read = 1'b1;
    @(negedge raw_clk);
    rx_read = 1'b0;
    chk("empty_read_count", fifo_count, 0);

    // Glitch shorter than half a bit
    rx_pin = 1'b0;
    repeat (3) @(negedge raw_clk);
    rx_pin = 1'b1;
    repeat (20) @(negedge raw_clk);
    chk("glitch_count", fifo_count, 0);
    chk("glitch_ferr", frame_error, 0);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    pop_chk("glitch_next", 8'h5A);

    // Table-driven frames
    for (int v = 0; v < 6; v++) begin
      repeat (4) @(negedge raw_clk);
      send_frame(tbl[v].data, tbl[v].stop, 1'b0, 1'b0);
      repeat (3) @(negedge raw_clk);
      chk($sformatf("tbl%0d_valid", v), rx_valid, tbl[v].exp_valid);
      chk($sformatf("tbl%0d_data", v), rx_data, tbl[v].exp_rdata);
      chk($sformatf("tbl%0d_ferr", v), frame_error, tbl[v].exp_ferr);
      if (rx_valid) begin
        rx_read = 1'b1;
        @(negedge raw_clk);
        rx_read = 1'b0;
      end
      pulse_clear();
      chk($sformatf("tbl%0d_cleared", v), frame_error, 0);
    end

    // Framing error with a long break, then recovery
    repeat (4) @(negedge raw_clk);
    frame_to_sample(8'h3C, 1'b0);
    clear_errors = 1'b1;
    @(negedge raw_clk);
    clear_errors = 1'b0;
    chk("ferr_set_wins", frame_error, 1);
    chk("ferr_count", fifo_count, 0);
    repeat (20) @(negedge raw_clk);
    pulse_clear();
    repeat (20) @(negedge raw_clk);
    chk("break_single_err", frame_error, 0);
    rx_pin = 1'b1;
    repeat (4) @(negedge raw_clk);
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    chk("after_break_count", fifo_count, 1);
    pop_chk("after_break", 8'h11);

    // Overflow: five back-to-back bytes, no reads
    for (int i = 1; i <= 5; i++) send_frame(i[7:0], 1'b1, 1'b0, 1'b0);
    chk("ovf_count", fifo_count, 4);
    chk("ovf_flag", rx_overflow, 1);
    for (int i = 1; i <= 4; i++) pop_chk($sformatf("ovf_pop%0d", i), i[7:0]);
    chk("ovf_drained", fifo_count, 0);
    chk("ovf_sticky", rx_overflow, 1);
    pulse_clear();
    chk("ovf_cleared", rx_overflow, 0);

    // Full FIFO: push and pop in the same cycle
    for (int i = 1; i <= 4; i++) send_frame(8'h60 + i[7:0], 1'b1, 1'b0, 1'b0);
    chk("full_count", fifo_count, 4);
    send_frame(8'h66, 1'b1, 1'b1, 1'b0);
    chk("pp_count", fifo_count, 4);
    chk("pp_ovf", rx_overflow, 0);
    pop_chk("pp_pop0", 8'h62);
    pop_chk("pp_pop1", 8'h63);
    pop_chk("pp_pop2", 8'h64);
    pop_chk("pp_pop3", 8'h66);
    chk("pp_empty", rx_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
